// File: rtl/x_stage_collector.sv
// Serialises the X-stage's four lane FIFOs, in strict round-robin order, into one framed output stream of N words.
// Optional build macro COLLECTOR_MOD_REDUCE_EN folds coefficients in [Q,2Q) back into [0,Q) before the output register.
module x_stage_collector #(
  parameter int              N  = 1024,
  parameter logic [63:0]     Q  = 64'd3221225473,
  parameter int              DW = 65
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ap_start,
  output logic          ap_ready,
  output logic          ap_done,
  output logic          ap_idle,
  input  logic [DW-1:0] in_streams_0_dout,
  input  logic          in_streams_0_empty_n,
  output logic          in_streams_0_read,
  input  logic [DW-1:0] in_streams_1_dout,
  input  logic          in_streams_1_empty_n,
  output logic          in_streams_1_read,
  input  logic [DW-1:0] in_streams_2_dout,
  input  logic          in_streams_2_empty_n,
  output logic          in_streams_2_read,
  input  logic [DW-1:0] in_streams_3_dout,
  input  logic          in_streams_3_empty_n,
  output logic          in_streams_3_read,
  output logic [DW-1:0] out_stream_din,
  input  logic          out_stream_full_n,
  output logic          out_stream_write,
  output logic          frame_err
);

  localparam int CW = $clog2(N + 1);
`ifdef COLLECTOR_MOD_REDUCE_EN
  localparam bit REDUCE = 1'b1;
`else
  localparam bit REDUCE = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state, state_next;
  logic [1:0]    lane, lane_next;
  logic [CW-1:0] count, count_next;
  logic          out_valid, out_valid_next;
  logic [DW-1:0] out_data, out_data_next;
  logic          frame_err_next;

  logic [DW-1:0] lane_dout [4];
  logic [3:0]    lane_empty_n;
  logic [3:0]    lane_read;
  logic [DW-1:0] head;
  logic [DW-2:0] coef;
  logic          last_word, frame_full, transfer, pop;

  always_comb begin
    lane_dout[0] = in_streams_0_dout;
    lane_dout[1] = in_streams_1_dout;
    lane_dout[2] = in_streams_2_dout;
    lane_dout[3] = in_streams_3_dout;
  end

  assign lane_empty_n = {in_streams_3_empty_n, in_streams_2_empty_n,
                         in_streams_1_empty_n, in_streams_0_empty_n};
  assign {in_streams_3_read, in_streams_2_read,
          in_streams_1_read, in_streams_0_read} = lane_read;

  assign head       = lane_dout[lane];
  assign coef       = (REDUCE && head[DW-2:0] >= Q) ? head[DW-2:0] - Q : head[DW-2:0];
  assign last_word  = (count == CW'(N - 1));
  assign frame_full = (count == CW'(N));
  assign transfer   = out_valid && out_stream_full_n;
  // The output register may reload in the same cycle it drains, giving one word per cycle.
  assign pop        = (state == S_RUN) && !frame_full && lane_empty_n[lane] &&
                      (!out_valid || out_stream_full_n);

  assign out_stream_din   = out_data;
  assign out_stream_write = out_valid;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next     = state;
    lane_next      = lane;
    count_next     = count;
    out_valid_next = out_valid;
    out_data_next  = out_data;
    frame_err_next = frame_err;
    lane_read      = '0;
    ap_ready       = 1'b0;
    ap_done        = 1'b0;
    ap_idle        = 1'b0;
    unique case (state)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          ap_ready       = 1'b1;
          state_next     = S_RUN;
          lane_next      = '0;
          count_next     = '0;
          out_valid_next = 1'b0;
          frame_err_next = 1'b0;
        end
      end
      S_RUN: begin
        if (transfer) out_valid_next = 1'b0;
        if (pop) begin
          lane_read[lane] = 1'b1;
          out_valid_next  = 1'b1;
          out_data_next   = {last_word, coef};
          lane_next       = lane + 2'd1;
          count_next      = count + CW'(1);
          // The incoming end-of-frame flag must agree with our own word count.
          if (head[DW-1] != last_word) frame_err_next = 1'b1;
        end
        if (frame_full && transfer) state_next = S_DONE;
      end
      S_DONE: begin
        ap_done    = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      lane      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      lane      <= lane_next;
      count     <= count_next;
      out_valid <= out_valid_next;
      out_data  <= out_data_next;
      frame_err <= frame_err_next;
    end
  end

endmodule

// File: tb/tb_x_stage_collector.sv
// Directed bench for x_stage_collector: lane FIFO models, output monitor, and a linear sequence of frame scenarios.
module tb_x_stage_collector;

  localparam int          N   = 1024;
  localparam logic [63:0] BIG = 64'd3221225480;
`ifdef COLLECTOR_MOD_REDUCE_EN
  localparam logic [63:0] BIG_OUT = 64'd7;
`else
  localparam logic [63:0] BIG_OUT = BIG;
`endif

  logic        clk = 1'b0;
  logic        reset, ap_start, out_full_n;
  logic        ap_ready, ap_done, ap_idle, out_write, frame_err;
  logic [64:0] din;
  logic [64:0] dout [4];
  logic [3:0]  empty_n, rd, hold;
  logic [64:0] lane_mem [4][256];
  int          rd_idx [4];
  logic        reload, mon_clear, big_mode;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  x_stage_collector dut (
    .clk(clk), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .in_streams_0_dout(dout[0]), .in_streams_0_empty_n(empty_n[0]), .in_streams_0_read(rd[0]),
    .in_streams_1_dout(dout[1]), .in_streams_1_empty_n(empty_n[1]), .in_streams_1_read(rd[1]),
    .in_streams_2_dout(dout[2]), .in_streams_2_empty_n(empty_n[2]), .in_streams_2_read(rd[2]),
    .in_streams_3_dout(dout[3]), .in_streams_3_empty_n(empty_n[3]), .in_streams_3_read(rd[3]),
    .out_stream_din(din), .out_stream_full_n(out_full_n), .out_stream_write(out_write),
    .frame_err(frame_err)
  );

  // FWFT lane FIFO models: head word plus a read pointer advanced by the DUT's read strobes.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      dout[k]    = lane_mem[k][(rd_idx[k] < 256) ? rd_idx[k] : 255];
      empty_n[k] = (rd_idx[k] < 256) && !hold[k];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (reload) rd_idx[k] <= 0;
      else if (rd[k]) rd_idx[k] <= rd_idx[k] + 1;
    end
  end

  // Output monitor: records transferred words and counts protocol violations.
  logic [64:0] got [N];
  int          got_n, reads_cnt, order_err, multi_err, stall_err, lat_err, done_cnt;
  logic        pend, stall_prev;
  logic [64:0] stall_din;

  always @(posedge clk) begin
    if (mon_clear) begin
      got_n <= 0; reads_cnt <= 0; order_err <= 0; multi_err <= 0;
      stall_err <= 0; lat_err <= 0; done_cnt <= 0; pend <= 1'b0; stall_prev <= 1'b0;
    end else begin
      if (out_write && out_full_n) begin
        if (got_n < N) got[got_n] <= din;
        got_n <= got_n + 1;
      end
      if ($countones(rd) > 1) multi_err <= multi_err + 1;
      if ($countones(rd) == 1) begin
        reads_cnt <= reads_cnt + 1;
        if (!rd[reads_cnt % 4]) order_err <= order_err + 1;
      end
      if (pend && !out_write) lat_err <= lat_err + 1;
      pend <= (rd != 4'b0);
      if (out_write && !out_full_n) begin
        if (rd != 4'b0) stall_err <= stall_err + 1;
        stall_din <= din;
      end
      stall_prev <= out_write && !out_full_n;
      if (stall_prev && din !== stall_din) stall_err <= stall_err + 1;
      if (ap_done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_lanes();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 256; i++)
        lane_mem[k][i] = {(k == 3 && i == 255), 64'(4 * i + k)};
  endtask

  task automatic prep();
    @(negedge clk); mon_clear = 1'b1; reload = 1'b1;
    @(negedge clk); mon_clear = 1'b0; reload = 1'b0;
  endtask

  task automatic start_frame(input string tag);
    @(negedge clk); ap_start = 1'b1;
    #1 check({tag, "_ready"}, ap_ready, 1);
    @(negedge clk); ap_start = 1'b0;
    check({tag, "_busy"}, ap_idle, 0);
  endtask

  task automatic wait_reads(input string tag, input int n);
    int cyc = 0;
    while (reads_cnt < n && cyc < 5000) begin @(negedge clk); cyc++; end
    check({tag, "_reads_reached"}, reads_cnt >= n, 1);
  endtask

  task automatic finish_frame(input string tag, input bit toggle, input bit exp_err, input int exp_cyc);
    int cyc = 0;
    int errs = 0;
    while (!ap_done && cyc < 5000) begin
      @(negedge clk); cyc++;
      if (toggle) out_full_n = ~out_full_n;
    end
    out_full_n = 1'b1;
    check({tag, "_done_seen"}, ap_done, 1);
    if (exp_cyc > 0) check({tag, "_cycles"}, cyc, exp_cyc);
    check({tag, "_idle_during_done"}, ap_idle, 0);
    check({tag, "_err_at_done"}, frame_err, exp_err);
    @(negedge clk);
    check({tag, "_idle_after"}, ap_idle, 1);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_word_count"}, got_n, N);
    for (int i = 0; i < N; i++)
      if (got[i] !== {(i == N - 1), (i == 0 && big_mode) ? BIG_OUT : 64'(i)}) errs++;
    check({tag, "_seq_errs"}, errs, 0);
    check({tag, "_order_errs"}, order_err, 0);
    check({tag, "_multi_read"}, multi_err, 0);
    check({tag, "_latency_errs"}, lat_err, 0);
    check({tag, "_stall_errs"}, stall_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ap_start = 1'b0; out_full_n = 1'b1; hold = '0;
    reload = 1'b1; mon_clear = 1'b1; big_mode = 1'b0;
    fill_lanes();
    repeat (3) @(negedge clk);
    check("rst_idle", ap_idle, 1);
    check("rst_ready", ap_ready, 0);
    check("rst_done", ap_done, 0);
    check("rst_write", out_write, 0);
    check("rst_din", din, 0);
    check("rst_reads", rd, 0);
    check("rst_err", frame_err, 0);
    reset = 1'b0;
    @(negedge clk); mon_clear = 1'b0; reload = 1'b0;

    // Frame A: all lanes full, no backpressure -> 1 word/cycle.
    prep();
    start_frame("a");
    finish_frame("a", 1'b0, 1'b0, 1025);

    // Frame B: full_n toggles every cycle.
    prep();
    start_frame("b");
    finish_frame("b", 1'b1, 1'b0, 0);

    // Frame C: lane 2 withheld for 10 cycles mid-frame; ap_start during RUN is ignored.
    prep();
    start_frame("c");
    wait_reads("c", 400);
    hold[2] = 1'b1;
    ap_start = 1'b1;
    #1 check("c_ready_ignored", ap_ready, 0);
    ap_start = 1'b0;
    repeat (10) @(negedge clk);
    check("c_stall_reads", reads_cnt, 402);
    check("c_stall_got_n", got_n, 402);
    check("c_last_before_stall", got[401], 65'd401);
    check("c_write_paused", out_write, 0);
    check("c_lane0_reads", rd_idx[0], 101);
    check("c_lane3_reads", rd_idx[3], 100);
    hold[2] = 1'b0;
    finish_frame("c", 1'b0, 1'b0, 0);

    // Frame D: stray flag on word 500, and an out-of-range coefficient on word 0.
    lane_mem[0][125][64] = 1'b1;
    lane_mem[0][0] = {1'b0, BIG};
    big_mode = 1'b1;
    prep();
    start_frame("d");
    wait_reads("d", 500);
    check("d_err_before", frame_err, 0);
    @(negedge clk);
    check("d_err_after", frame_err, 1);
    finish_frame("d", 1'b0, 1'b1, 0);
    fill_lanes();
    big_mode = 1'b0;

    // Frame E: new start clears frame_err; reset pulsed at word 300.
    prep();
    start_frame("e");
    check("e_err_cleared", frame_err, 0);
    wait_reads("e", 300);
    reset = 1'b1;
    #1;
    check("e_rst_idle", ap_idle, 1);
    check("e_rst_write", out_write, 0);
    check("e_rst_reads", rd, 0);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    check("e_post_rst_reads", rd, 0);
    check("e_post_rst_idle", ap_idle, 1);

    // Frame F: fresh frame after the reset.
    prep();
    start_frame("f");
    finish_frame("f", 1'b0, 1'b0, 1025);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
